// File: rtl/padd_pkg.sv
// rtl/padd_pkg.sv - shared state encoding and derived-width helpers for the streaming padder
package padd_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        OUT  = 2'd2
    } state_t;

    function automatic int pay_w(input int block_w, input int len_w);
        return block_w - len_w;
    endfunction

    function automatic int nwords(input int block_w, input int len_w, input int data_w);
        return (block_w - len_w) / data_w;
    endfunction

    function automatic int bits_w(input int data_w);
        return $clog2(data_w + 1);
    endfunction

endpackage

// File: rtl/padd_mask.sv
// rtl/padd_mask.sv - combinational payload mask, optional marker bit and length-field insert
module padd_mask
    import padd_pkg::*;
#(
    parameter int  BLOCK_W = 256,
    parameter int  LEN_W   = 8,
    localparam int PAY_W   = pay_w(BLOCK_W, LEN_W)
) (
    input  logic [PAY_W-1:0]   acc,
    input  logic [LEN_W-1:0]   len,
    input  logic               mode,
    output logic [BLOCK_W-1:0] block
);

    logic [PAY_W-1:0] payload;

    // i never reaches PAY_W, so a full-length message naturally gets no marker
    always_comb begin
        payload = '0;
        for (int i = 0; i < PAY_W; i++) begin
            payload[i] = (acc[i] && (i < int'(len))) || (mode && (i == int'(len)));
        end
    end

    assign block = {len, payload};

endmodule

// File: rtl/padd_stream.sv
// rtl/padd_stream.sv - packs a word stream into one padded, length-tagged block per message
module padd_stream
    import padd_pkg::*;
#(
    parameter int  BLOCK_W = 256,
    parameter int  LEN_W   = 8,
    parameter int  DATA_W  = 8,
    localparam int BITS_W  = bits_w(DATA_W)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               mode,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_last,
    input  logic [BITS_W-1:0]  in_bits,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_block,
    output logic               out_ovf
);

    localparam int PAY_W  = pay_w(BLOCK_W, LEN_W);
    localparam int NWORDS = nwords(BLOCK_W, LEN_W, DATA_W);
    localparam int CNT_W  = $clog2(NWORDS + 1);

    generate
        if (PAY_W % DATA_W != 0) begin : g_bad_data_w
            $error("padd_stream: payload width must be a multiple of DATA_W");
        end
        if ((2 ** LEN_W) <= PAY_W) begin : g_bad_len_w
            $error("padd_stream: LEN_W too narrow to hold the payload length");
        end
    endgenerate

    state_t               state, state_nx;
    logic [CNT_W-1:0]     cnt;
    logic [PAY_W-1:0]     acc;
    logic [LEN_W-1:0]     len;
    logic                 mode_q;
    logic                 ovf;
    logic [BLOCK_W-1:0]   block_q;
    logic                 ovf_q;
    logic [BLOCK_W-1:0]   mask_block;
    logic [LEN_W-1:0]     beat_bits;
    logic                 accept;
    logic                 has_room;

    assign accept   = in_valid && in_ready;
    assign has_room = cnt < CNT_W'(NWORDS);

    // only the last beat can be partial; oversized counts clamp to a full word
    always_comb begin
        beat_bits = LEN_W'(DATA_W);
        if (in_last && (in_bits <= BITS_W'(DATA_W))) begin
            beat_bits = LEN_W'(in_bits);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            FILL:    if (accept && in_last) state_nx = PAD;
            PAD:     state_nx = OUT;
            OUT:     if (out_ready) state_nx = FILL;
            default: state_nx = FILL;
        endcase
    end

    always_comb begin
        in_ready  = (state == FILL);
        out_valid = (state == OUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            acc     <= '0;
            len     <= '0;
            mode_q  <= 1'b0;
            ovf     <= 1'b0;
            block_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        if (cnt == '0) mode_q <= mode;
                        if (has_room) begin
                            acc[int'(cnt) * DATA_W +: DATA_W] <= in_data;
                            cnt <= cnt + CNT_W'(1);
                            len <= len + beat_bits;
                        end else begin
                            ovf <= 1'b1;
                            len <= LEN_W'(PAY_W);
                        end
                    end
                end
                PAD: begin
                    block_q <= mask_block;
                    ovf_q   <= ovf;
                end
                OUT: begin
                    if (out_ready) begin
                        cnt <= '0;
                        acc <= '0;
                        len <= '0;
                        ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    padd_mask #(
        .BLOCK_W(BLOCK_W),
        .LEN_W  (LEN_W)
    ) u_mask (
        .acc  (acc),
        .len  (len),
        .mode (mode_q),
        .block(mask_block)
    );

    assign out_block = block_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_padd_stream.sv
// tb/tb_padd_stream.sv - self-checking bench for padd_stream
module tb_padd_stream;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mode = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [7:0]   in_data = '0;
    logic         in_last = 1'b0;
    logic [3:0]   in_bits = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [255:0] out_block;
    logic         out_ovf;

    always #5 clk = ~clk;

    padd_stream #(
        .BLOCK_W(256),
        .LEN_W  (8),
        .DATA_W (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mode     (mode),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_bits  (in_bits),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_block(out_block),
        .out_ovf  (out_ovf)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] words [0:39];

    typedef struct {
        bit          m;
        int          n;
        logic [7:0]  w0, w1, w2, fill;
        int          lb;
        int          hold;
        int          exp_len;
        bit          exp_ovf;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Message as a flat bit stream: keep at most 248 bits, zero the rest, tag the length
    function automatic logic [255:0] ref_block(input bit m, input int n, input int lb);
        bit q[$];
        logic [255:0] b;
        int nb;
        int len;
        for (int k = 0; k < n && k < 31; k++) begin
            nb = (k == n - 1) ? ((lb > 8) ? 8 : lb) : 8;
            for (int j = 0; j < nb; j++) q.push_back(words[k][j]);
        end
        len = q.size();
        b = '0;
        for (int i = 0; i < len; i++) b[i] = q[i];
        if (m && len < 248) b[len] = 1'b1;
        b[255:248] = len[7:0];
        return b;
    endfunction

    task automatic run_msg(input bit m, input int n, input int lb, input int hold,
                           output logic [255:0] blk, output logic ov);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_data  = words[k];
            in_last  = (k == n - 1);
            in_bits  = (k == n - 1) ? lb[3:0] : 4'($urandom_range(0, 15));
            mode     = (k == 0) ? m : ~m;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("lat_t1_valid", out_valid, 1'b0);
        chk("lat_t1_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        chk("lat_t2_valid", out_valid, 1'b1);
        blk = out_block;
        ov  = out_ovf;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            in_last  = 1'b1;
            in_bits  = 4'd8;
            @(posedge clk); #1;
            chk("hold_block", out_block, blk);
            chk("hold_ready", in_ready, 1'b0);
            chk("hold_valid", out_valid, 1'b1);
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("rel_valid", out_valid, 1'b0);
        chk("rel_ready", in_ready, 1'b1);
    endtask

    task automatic load_words(input vec_t v);
        for (int k = 0; k < 40; k++) begin
            words[k] = (k == 0) ? v.w0 : (k == 1) ? v.w1 : (k == 2) ? v.w2 :
                       (k >= 31) ? 8'hC3 : v.fill;
        end
    endtask

    initial begin
        logic [255:0] blk;
        logic ov;
        int n, lb;
        bit m;

        tbl.push_back('{1'b0,  3, 8'hAA, 8'hBB, 8'hCC, 8'h00,  8, 5,  24, 1'b0, 32'h00CCBBAA});
        tbl.push_back('{1'b1,  2, 8'hFF, 8'hFF, 8'h00, 8'h00,  4, 0,  12, 1'b0, 32'h00001FFF});
        tbl.push_back('{1'b1,  1, 8'hFF, 8'h00, 8'h00, 8'h00,  0, 1,   0, 1'b0, 32'h00000001});
        tbl.push_back('{1'b0,  1, 8'hFF, 8'h00, 8'h00, 8'h00,  0, 0,   0, 1'b0, 32'h00000000});
        tbl.push_back('{1'b1, 31, 8'h5A, 8'h5A, 8'h5A, 8'h5A,  8, 0, 248, 1'b0, 32'h5A5A5A5A});
        tbl.push_back('{1'b1, 33, 8'h5A, 8'h5A, 8'h5A, 8'h5A,  8, 0, 248, 1'b1, 32'h5A5A5A5A});
        tbl.push_back('{1'b1,  1, 8'hFF, 8'h00, 8'h00, 8'h00, 15, 0,   8, 1'b0, 32'h000001FF});
        tbl.push_back('{1'b1,  2, 8'hFF, 8'hFF, 8'h00, 8'h00,  8, 0,  16, 1'b0, 32'h0001FFFF});
        tbl.push_back('{1'b0, 31, 8'h5A, 8'h5A, 8'h5A, 8'h5A,  3, 0, 243, 1'b0, 32'h5A5A5A5A});

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_block", out_block, '0);
        chk("rst_out_ovf", out_ovf, 1'b0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            load_words(tbl[i]);
            run_msg(tbl[i].m, tbl[i].n, tbl[i].lb, tbl[i].hold, blk, ov);
            chk($sformatf("vec%0d_len", i), blk[255:248], tbl[i].exp_len[7:0]);
            chk($sformatf("vec%0d_ovf", i), ov, tbl[i].exp_ovf);
            chk($sformatf("vec%0d_lo", i), blk[31:0], tbl[i].exp_lo);
            chk($sformatf("vec%0d_block", i), blk, ref_block(tbl[i].m, tbl[i].n, tbl[i].lb));
        end

        for (int r = 0; r < 25; r++) begin
            m  = 1'($urandom);
            n  = $urandom_range(1, 34);
            lb = $urandom_range(0, 15);
            for (int k = 0; k < 40; k++) words[k] = 8'($urandom);
            run_msg(m, n, lb, $urandom_range(0, 2), blk, ov);
            chk($sformatf("rnd%0d_block", r), blk, ref_block(m, n, lb));
            chk($sformatf("rnd%0d_ovf", r), ov, (n > 31));
        end

        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = 8'h77;
            in_last  = 1'b0;
            mode     = 1'b1;
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("abort_out_valid", out_valid, 1'b0);
        chk("abort_out_block", out_block, '0);
        chk("abort_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("abort_no_block", out_valid, 1'b0);
        end
        for (int k = 0; k < 40; k++) words[k] = 8'h00;
        words[0] = 8'h01;
        run_msg(1'b0, 1, 8, 0, blk, ov);
        chk("post_abort_block", blk, {8'd8, 240'd0, 8'h01});
        chk("post_abort_ovf", ov, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
